// File: rtl/poly_mod_sq_iter_pkg.sv
// Shared types and helpers for the repeated modular squaring engine.
// Holds the FSM encoding, the default coefficient layout and the default modulus.
package poly_mod_sq_iter_pkg;

    localparam int WORD_BITS_DEF  = 35;
    localparam int NUM_WORDS_DEF  = 30;
    localparam int REDUN_BITS_DEF = 1;
    localparam int I_WORD_DEF     = NUM_WORDS_DEF + 1;
    localparam int COEF_BITS_DEF  = WORD_BITS_DEF + REDUN_BITS_DEF;

    // Default 1024-bit odd modulus, 2^1024 - 189.
    localparam logic [1023:0] MODULUS_DEF = ~1024'd188;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_REDUCE,
        ST_WAIT_R,
        ST_HOLD
    } state_e;

    typedef logic [I_WORD_DEF-1:0][COEF_BITS_DEF-1:0] coef_arr_t;

    function automatic int pass_latency(input int in_pipes, input int core_lat, input int out_pipes);
        return 1 + in_pipes + core_lat + out_pipes;
    endfunction

endpackage

// File: rtl/poly_mod_mult.sv
// Behavioural modular multiply/square core: a*b mod MODULUS (or a mod MODULUS when reduce-only).
// Latency 2 cycles for REDUCTION_BITS>8 else 1; fully pipelined, no backpressure.
module poly_mod_mult
    import poly_mod_sq_iter_pkg::*;
#(
    parameter int            WORD_BITS       = 35,
    parameter int            NUM_WORDS       = 30,
    parameter logic [1023:0] MODULUS         = MODULUS_DEF,
    parameter int            REDUCTION_BITS  = 15,
    parameter int            REDUN_WORD_BITS = 1,
    parameter int            SQ_MODE         = 1,
    parameter int            I_WORD          = NUM_WORDS + 1,
    parameter int            COEF_BITS       = WORD_BITS + REDUN_WORD_BITS
) (
    input  logic                              i_clk,
    input  logic                              i_rst,
    input  logic                              i_val,
    input  logic                              i_reduce_only,
    input  logic [I_WORD-1:0][COEF_BITS-1:0]  i_dat_a,
    input  logic [I_WORD-1:0][COEF_BITS-1:0]  i_dat_b,
    output logic                              o_val,
    output logic [I_WORD-1:0][COEF_BITS-1:0]  o_dat
);

    localparam int LAT = (REDUCTION_BITS > 8) ? 2 : 1;
    localparam int VW  = I_WORD * WORD_BITS + COEF_BITS + 8;
    localparam int PW  = 2 * VW;
    localparam int RW  = I_WORD * WORD_BITS;

    typedef logic [I_WORD-1:0][COEF_BITS-1:0] dat_t;

    logic [VW-1:0] a_int, b_int;
    logic [PW-1:0] prod;
    logic [RW-1:0] rem;
    dat_t          res;
    logic [LAT-1:0] val_d, val_q;
    dat_t          dat_d [LAT];
    dat_t          dat_q [LAT];

    // Redundant words overlap by REDUN_WORD_BITS; summing them resolves the carries.
    always_comb begin
        a_int = '0;
        b_int = '0;
        for (int i = 0; i < I_WORD; i++) begin
            a_int = a_int + (VW'(i_dat_a[i]) << (i * WORD_BITS));
            b_int = b_int + (VW'((SQ_MODE != 0) ? i_dat_a[i] : i_dat_b[i]) << (i * WORD_BITS));
        end
        prod = i_reduce_only ? PW'(a_int) : PW'(a_int) * PW'(b_int);
        rem  = RW'(prod % PW'(MODULUS));
        res  = '0;
        for (int i = 0; i < I_WORD; i++) begin
            res[i] = COEF_BITS'(rem[i*WORD_BITS +: WORD_BITS]);
        end
    end

    always_comb begin
        val_d[0] = i_val;
        dat_d[0] = res;
        for (int k = 1; k < LAT; k++) begin
            val_d[k] = val_q[k-1];
            dat_d[k] = dat_q[k-1];
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            val_q <= '0;
        end else begin
            val_q <= val_d;
        end
    end

    always_ff @(posedge i_clk) begin
        for (int k = 0; k < LAT; k++) begin
            dat_q[k] <= dat_d[k];
        end
    end

    assign o_val = val_q[LAT-1];
    assign o_dat = dat_q[LAT-1];

endmodule

// File: rtl/poly_mod_sq_pipe.sv
// Generic DEPTH-stage valid/data shift register; latency DEPTH cycles, no backpressure.
// Only the valid bits are reset, data registers free-run.
module poly_mod_sq_pipe #(
    parameter int W     = 8,
    parameter int DEPTH = 1
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_val,
    input  logic [W-1:0] i_dat,
    output logic         o_val,
    output logic [W-1:0] o_dat
);

    logic [DEPTH-1:0] val_d, val_q;
    logic [W-1:0]     dat_d [DEPTH];
    logic [W-1:0]     dat_q [DEPTH];

    always_comb begin
        val_d[0] = i_val;
        dat_d[0] = i_dat;
        for (int k = 1; k < DEPTH; k++) begin
            val_d[k] = val_q[k-1];
            dat_d[k] = dat_q[k-1];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            val_q <= '0;
        end else begin
            val_q <= val_d;
        end
    end

    always_ff @(posedge i_clk) begin
        for (int k = 0; k < DEPTH; k++) begin
            dat_q[k] <= dat_d[k];
        end
    end

    assign o_val = val_q[DEPTH-1];
    assign o_dat = dat_q[DEPTH-1];

endmodule

// File: rtl/poly_mod_sq_iter.sv
// x^(2^T) mod MODULUS by T feedback squarings plus one reduce pass; one job at a time, result held until i_rdy.
// Job latency (T+1)*(1+IN_PIPES+L+OUT_PIPES); POLY_MOD_SQ_ITER_CKPT_EN adds a checkpoint monitoring tap.
module poly_mod_sq_iter
    import poly_mod_sq_iter_pkg::*;
#(
    parameter int            WORD_BITS       = 35,
    parameter int            NUM_WORDS       = 30,
    parameter logic [1023:0] MODULUS         = MODULUS_DEF,
    parameter int            REDUCTION_BITS  = 15,
    parameter int            REDUN_WORD_BITS = 1,
    parameter int            I_WORD          = NUM_WORDS + 1,
    parameter int            COEF_BITS       = WORD_BITS + REDUN_WORD_BITS,
    parameter int            IN_PIPES        = 3,
    parameter int            OUT_PIPES       = 3,
`ifdef POLY_MOD_SQ_ITER_CKPT_EN
    parameter int            CKPT_LOG2       = 10,
`endif
    parameter int            ITER_BITS       = 32
) (
    input  logic                              i_clk,
    input  logic                              i_rst_n,
    input  logic                              i_val,
    output logic                              o_rdy,
    input  logic [I_WORD-1:0][COEF_BITS-1:0]  i_dat,
    input  logic [ITER_BITS-1:0]              i_iter,
    output logic                              o_val,
    input  logic                              i_rdy,
    output logic [I_WORD-1:0][COEF_BITS-1:0]  o_dat,
    output logic [ITER_BITS-1:0]              o_iter_cnt,
`ifdef POLY_MOD_SQ_ITER_CKPT_EN
    output logic                              o_ckpt_val,
    output logic [I_WORD-1:0][COEF_BITS-1:0]  o_ckpt_dat,
`endif
    output logic                              o_busy
);

    localparam int DW = I_WORD * COEF_BITS;

    typedef logic [I_WORD-1:0][COEF_BITS-1:0] dat_t;

    state_e               state_d, state_q;
    dat_t                 x_d, x_q, res_d, res_q;
    logic [ITER_BITS-1:0] t_d, t_q, cnt_d, cnt_q, cnt_inc;
    logic                 busy_d, busy_q, oval_d, oval_q;
    logic                 inj_vld, inj_red;
    logic [DW:0]          in_pipe_dat;
    logic                 core_in_vld, core_out_vld, out_vld;
    logic                 core_in_red;
    dat_t                 core_in_dat, core_out_dat, out_dat;
    logic [DW-1:0]        out_pipe_dat;

    assign cnt_inc = cnt_q + ITER_BITS'(1);

    poly_mod_sq_pipe #(.W(DW + 1), .DEPTH(IN_PIPES)) u_in_pipe (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_val   (inj_vld),
        .i_dat   ({inj_red, x_q}),
        .o_val   (core_in_vld),
        .o_dat   (in_pipe_dat)
    );

    assign core_in_red = in_pipe_dat[DW];
    assign core_in_dat = in_pipe_dat[DW-1:0];

    poly_mod_mult #(
        .WORD_BITS       (WORD_BITS),
        .NUM_WORDS       (NUM_WORDS),
        .MODULUS         (MODULUS),
        .REDUCTION_BITS  (REDUCTION_BITS),
        .REDUN_WORD_BITS (REDUN_WORD_BITS),
        .SQ_MODE         (1),
        .I_WORD          (I_WORD),
        .COEF_BITS       (COEF_BITS)
    ) u_core (
        .i_clk         (i_clk),
        .i_rst         (~i_rst_n),
        .i_val         (core_in_vld),
        .i_reduce_only (core_in_red),
        .i_dat_a       (core_in_dat),
        .i_dat_b       (core_in_dat),
        .o_val         (core_out_vld),
        .o_dat         (core_out_dat)
    );

    poly_mod_sq_pipe #(.W(DW), .DEPTH(OUT_PIPES)) u_out_pipe (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_val   (core_out_vld),
        .i_dat   (core_out_dat),
        .o_val   (out_vld),
        .o_dat   (out_pipe_dat)
    );

    assign out_dat = out_pipe_dat;

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        res_d   = res_q;
        t_d     = t_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        oval_d  = oval_q;
        inj_vld = 1'b0;
        inj_red = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (i_val) begin
                    x_d     = i_dat;
                    t_d     = i_iter;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = (i_iter != '0) ? ST_ISSUE : ST_REDUCE;
                end
            end
            ST_ISSUE: begin
                inj_vld = 1'b1;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // Compare against cnt+1 so a count of all-ones never wraps past T.
                if (out_vld) begin
                    x_d     = out_dat;
                    cnt_d   = cnt_inc;
                    state_d = (cnt_inc == t_q) ? ST_REDUCE : ST_ISSUE;
                end
            end
            ST_REDUCE: begin
                inj_vld = 1'b1;
                inj_red = 1'b1;
                state_d = ST_WAIT_R;
            end
            ST_WAIT_R: begin
                if (out_vld) begin
                    res_d   = out_dat;
                    oval_d  = 1'b1;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (i_rdy) begin
                    oval_d  = 1'b0;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            oval_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            oval_q  <= oval_d;
        end
    end

    always_ff @(posedge i_clk) begin
        x_q   <= x_d;
        t_q   <= t_d;
        res_q <= res_d;
    end

`ifdef POLY_MOD_SQ_ITER_CKPT_EN
    logic ckpt_val_d, ckpt_val_q;
    dat_t ckpt_dat_d, ckpt_dat_q;

    always_comb begin
        ckpt_val_d = 1'b0;
        ckpt_dat_d = ckpt_dat_q;
        if (state_q == ST_WAIT && out_vld && cnt_inc[CKPT_LOG2-1:0] == '0) begin
            ckpt_val_d = 1'b1;
            ckpt_dat_d = out_dat;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ckpt_val_q <= 1'b0;
        end else begin
            ckpt_val_q <= ckpt_val_d;
        end
    end

    always_ff @(posedge i_clk) begin
        ckpt_dat_q <= ckpt_dat_d;
    end

    assign o_ckpt_val = ckpt_val_q;
    assign o_ckpt_dat = ckpt_dat_q;
`endif

    // Gated with reset so no job is offered while the block is held in reset.
    assign o_rdy      = (state_q == ST_IDLE) && i_rst_n;
    assign o_val      = oval_q;
    assign o_dat      = res_q;
    assign o_iter_cnt = cnt_q;
    assign o_busy     = busy_q;

endmodule

// File: tb/tb_poly_mod_sq_iter.sv
// Directed bench for poly_mod_sq_iter: vector table of jobs plus hold, reset and checkpoint sequences.
module tb_poly_mod_sq_iter;
    import poly_mod_sq_iter_pkg::*;

    localparam int PASS = 1 + 3 + 2 + 3;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 i_val, i_rdy, o_rdy, o_val, o_busy;
    coef_arr_t            i_dat, o_dat;
    logic [31:0]          i_iter, o_iter_cnt;
`ifdef POLY_MOD_SQ_ITER_CKPT_EN
    logic                 o_ckpt_val;
    coef_arr_t            o_ckpt_dat;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    poly_mod_sq_iter #(
`ifdef POLY_MOD_SQ_ITER_CKPT_EN
        .CKPT_LOG2 (1),
`endif
        .IN_PIPES  (3),
        .OUT_PIPES (3)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_val      (i_val),
        .o_rdy      (o_rdy),
        .i_dat      (i_dat),
        .i_iter     (i_iter),
        .o_val      (o_val),
        .i_rdy      (i_rdy),
        .o_dat      (o_dat),
        .o_iter_cnt (o_iter_cnt),
`ifdef POLY_MOD_SQ_ITER_CKPT_EN
        .o_ckpt_val (o_ckpt_val),
        .o_ckpt_dat (o_ckpt_dat),
`endif
        .o_busy     (o_busy)
    );

    typedef struct {
        logic [1023:0] x;
        logic [31:0]   t;
        logic [1199:0] exp;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [1199:0] act, input logic [1199:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    function automatic coef_arr_t to_coef(input logic [1023:0] x);
        logic [I_WORD_DEF*WORD_BITS_DEF-1:0] xe;
        coef_arr_t c;
        xe = (I_WORD_DEF*WORD_BITS_DEF)'(x);
        for (int i = 0; i < I_WORD_DEF; i++) begin
            c[i] = {1'b0, xe[i*WORD_BITS_DEF +: WORD_BITS_DEF]};
        end
        return c;
    endfunction

    function automatic logic [1199:0] to_int(input coef_arr_t c);
        logic [1199:0] acc;
        acc = '0;
        for (int i = 0; i < I_WORD_DEF; i++) begin
            acc = acc + (1200'(c[i]) << (i * WORD_BITS_DEF));
        end
        return acc % 1200'(MODULUS_DEF);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Submits one job, scrambles the inputs, and waits for o_val; lat counts edges after acceptance.
    task automatic run_job(input logic [1023:0] x, input logic [31:0] t,
                           output logic [1199:0] res, output int lat, output logic ok);
        int w;
        w = 0;
        while (!o_rdy && w < 100) begin
            step();
            w++;
        end
        i_dat  = to_coef(x);
        i_iter = t;
        i_val  = 1'b1;
        step();
        i_val  = 1'b0;
        i_dat  = to_coef(1024'd12345);
        i_iter = 32'd7;
        lat = 0;
        while (!o_val && lat < 4000) begin
            step();
            lat++;
        end
        ok  = o_val;
        res = to_int(o_dat);
    endtask

`ifdef POLY_MOD_SQ_ITER_CKPT_EN
    logic          ckpt_on = 1'b0;
    logic [31:0]   ck_cnt [$];
    logic [1199:0] ck_dat [$];

    always @(posedge clk) begin
        #1;
        if (ckpt_on && o_ckpt_val) begin
            ck_cnt.push_back(o_iter_cnt);
            ck_dat.push_back(to_int(o_ckpt_dat));
        end
    end
`endif

    initial begin
        #2000000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1199:0] res;
        int            lat;
        logic          ok;
        logic          stable;
        logic          quiet;

        vecs[0] = '{x: 1024'd2, t: 32'd3, exp: 1200'd256};
        vecs[1] = '{x: 1024'd3, t: 32'd0, exp: 1200'd3};
        vecs[2] = '{x: MODULUS_DEF - 1024'd1, t: 32'd1, exp: 1200'd1};
        vecs[3] = '{x: 1024'd0, t: 32'd5, exp: 1200'd0};
        vecs[4] = '{x: 1024'd7, t: 32'd2, exp: 1200'd2401};
        vecs[5] = '{x: 1024'd2, t: 32'd1, exp: 1200'd4};

        rst_n  = 1'b0;
        i_val  = 1'b0;
        i_rdy  = 1'b0;
        i_dat  = '0;
        i_iter = '0;
        #2;
        check("reset_o_rdy", o_rdy, 0);
        check("reset_o_val", o_val, 0);
        check("reset_o_busy", o_busy, 0);
        check("reset_o_iter_cnt", o_iter_cnt, 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("post_reset_o_rdy", o_rdy, 1);

        for (int v = 0; v < 6; v++) begin
            i_rdy = 1'b1;
            run_job(vecs[v].x, vecs[v].t, res, lat, ok);
            check($sformatf("v%0d_timeout", v), ok, 1);
            check($sformatf("v%0d_result", v), res, vecs[v].exp);
            check($sformatf("v%0d_iter_cnt", v), o_iter_cnt, 1200'(vecs[v].t));
            check($sformatf("v%0d_latency", v), 1200'(lat), 1200'((vecs[v].t + 1) * PASS));
            check($sformatf("v%0d_busy_at_result", v), o_busy, 1);
            step();
            check($sformatf("v%0d_o_val_single_pulse", v), o_val, 0);
            check($sformatf("v%0d_o_rdy_after", v), o_rdy, 1);
            check($sformatf("v%0d_o_busy_after", v), o_busy, 0);
        end

        // Backpressure: result held stable across 20 stalled cycles.
        i_rdy = 1'b0;
        run_job(1024'd5, 32'd2, res, lat, ok);
        check("hold_timeout", ok, 1);
        stable = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if (o_val !== 1'b1 || to_int(o_dat) !== 1200'd625 || o_rdy !== 1'b0) stable = 1'b0;
            step();
        end
        check("hold_stable_20", stable, 1);
        check("hold_o_val_still", o_val, 1);
        check("hold_result", to_int(o_dat), 1200'd625);
        i_rdy = 1'b1;
        step();
        check("hold_release_o_val", o_val, 0);
        check("hold_release_o_rdy", o_rdy, 1);

        // Reset in the middle of a long job.
        i_dat  = to_coef(1024'd3);
        i_iter = 32'd100;
        i_val  = 1'b1;
        step();
        i_val = 1'b0;
        repeat (3 * PASS + 5) step();
        check("midjob_iter_cnt", o_iter_cnt, 3);
        check("midjob_busy", o_busy, 1);
        rst_n = 1'b0;
        #1;
        check("midreset_o_val", o_val, 0);
        check("midreset_o_busy", o_busy, 0);
        check("midreset_o_iter_cnt", o_iter_cnt, 0);
        check("midreset_o_rdy", o_rdy, 0);
        repeat (3) step();
        rst_n = 1'b1;
        #1;
        check("after_reset_o_rdy", o_rdy, 1);
        quiet = 1'b1;
        for (int k = 0; k < 2 * PASS; k++) begin
            if (o_val !== 1'b0 || o_busy !== 1'b0) quiet = 1'b0;
            step();
        end
        check("after_reset_no_stale_o_val", quiet, 1);
        run_job(1024'd2, 32'd1, res, lat, ok);
        check("after_reset_timeout", ok, 1);
        check("after_reset_result", res, 1200'd4);
        check("after_reset_latency", 1200'(lat), 1200'(2 * PASS));
        step();

`ifdef POLY_MOD_SQ_ITER_CKPT_EN
        ckpt_on = 1'b1;
        run_job(1024'd2, 32'd4, res, lat, ok);
        ckpt_on = 1'b0;
        check("ckpt_timeout", ok, 1);
        check("ckpt_final_result", res, 1200'd65536);
        check("ckpt_pulse_count", 1200'(ck_cnt.size()), 2);
        if (ck_cnt.size() == 2) begin
            check("ckpt0_iter", ck_cnt[0], 2);
            check("ckpt0_value", ck_dat[0], 1200'd16);
            check("ckpt1_iter", ck_cnt[1], 4);
            check("ckpt1_value", ck_dat[1], 1200'd65536);
        end
        step();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/poly_mod_sq_iter.md
Name: poly_mod_sq_iter

Overview:
- Repeated modular squaring engine for the VDF datapath.
- Accepts a redundant-form value x and an iteration count T. Feeds x through a squaring core (poly_mod_mult, SQ_MODE=1) T times via an internal feedback loop, then runs one reduce-only pass.
- Returns x^(2^T) mod MODULUS under a valid/ready handshake.
- Successor to the fixed-3-stage square wrapper: adds configurable in/out pipe depth, iteration sequencing, backpressure and progress reporting.

Parameters:
- WORD_BITS, 35, bits per coefficient word.
- NUM_WORDS, 30, words in the operand.
- MODULUS, 1024-bit RSA default of the codebase, modulus N.
- REDUCTION_BITS, 15, core reduction LUT address bits.
- REDUN_WORD_BITS, 1, redundant bits per coefficient.
- I_WORD, NUM_WORDS+1, coefficient count.
- COEF_BITS, WORD_BITS+REDUN_WORD_BITS, coefficient width.
- IN_PIPES, 3, register stages between the feedback mux and the core input (≥1).
- OUT_PIPES, 3, register stages between the core output and the feedback/result point (≥1).
- ITER_BITS, 32, width of the iteration count.
- CKPT_LOG2, 10, checkpoint interval 2^CKPT_LOG2 (used only with the optional feature).

Ports:
- i_clk, in, 1, clock.
- i_rst_n, in, 1, asynchronous active-low reset.
- i_val, in, 1, job valid.
- o_rdy, out, 1, block ready to accept a job.
- i_dat, in, [I_WORD][COEF_BITS], start value x.
- i_iter, in, ITER_BITS, squaring count T.
- o_val, out, 1, result valid.
- i_rdy, in, 1, downstream ready.
- o_dat, out, [I_WORD][COEF_BITS], result.
- o_iter_cnt, out, ITER_BITS, squarings completed in the current job.
- o_busy, out, 1, job in progress.

Behaviour:
- Reset: one clock domain; i_rst_n is asynchronous active-low.
  - Asserting i_rst_n=0 clears the FSM to IDLE, all pipe valid bits, o_val, o_iter_cnt and o_busy to 0. o_rdy is 0 during reset and 1 after release.
  - Data registers need no reset. The core reset is driven by ~i_rst_n.
- FSM states: IDLE, ISSUE, WAIT, REDUCE, WAIT_R, HOLD.
  - IDLE: o_rdy=1. On i_val&&o_rdy, latch i_dat and T, clear o_iter_cnt, set o_busy. Go to ISSUE if T>0, else REDUCE.
  - ISSUE: inject the operand (latched input on the first pass, fed-back result afterwards) into the input pipe with reduce_only=0 for exactly one cycle. Go to WAIT.
  - WAIT: wait for the valid to exit the output pipe. Capture data and increment o_iter_cnt. If o_iter_cnt+1==T go to REDUCE, else ISSUE.
  - REDUCE: inject the current value with reduce_only=1 for one cycle. Go to WAIT_R.
  - WAIT_R: on output-pipe valid, load o_dat, assert o_val. Go to HOLD.
  - HOLD: o_val and o_dat stay stable until i_rdy. On o_val&&i_rdy, deassert o_val and o_busy; go to IDLE. o_rdy returns to 1 the cycle after the transfer.
- Only one token is ever in flight. Core o_val is the sole completion indicator; the core latency L is not hard-coded.
- Per-pass latency is 1+IN_PIPES+L+OUT_PIPES cycles. Job latency is (T+1) passes.
- i_iter is sampled only at acceptance. Input changes during a job are ignored.
- Boundary cases:
  - T=0: reduce pass only.
  - T=2^ITER_BITS−1: no wrap; o_iter_cnt saturates exactly at T.
  - i_val held during HOLD: no acceptance until IDLE.
  - Reset mid-job: in-flight core result is discarded; after release the block is idle and emits no stale o_val.

Optional Feature:
- Macro: POLY_MOD_SQ_ITER_CKPT_EN.
- With the macro: adds outputs o_ckpt_val (1) and o_ckpt_dat (same width as o_dat).
  - Each time o_iter_cnt reaches a nonzero multiple of 2^CKPT_LOG2, the pre-reduce value is presented for one cycle with o_ckpt_val=1. There is no handshake; it is a monitoring tap.
  - o_ckpt_val resets to 0.
- Without the macro: ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package poly_mod_sq_iter_pkg holds:
  - fsm state enum typedef;
  - coefficient-array typedef parametrised by I_WORD/COEF_BITS (via parameterised struct or localparams);
  - helper function computing the per-pass latency for benches.
- One sub-module, poly_mod_sq_pipe: generic N-stage val/data shift register with async active-low reset on valid bits only. Instantiated twice (IN_PIPES, OUT_PIPES).
- The core is poly_mod_mult instantiated directly.

Test Plan:
- x=2, T=3, i_rdy=1 → o_dat converts to 256; o_iter_cnt=3; o_val asserted one pulse at 4 passes after acceptance.
- x=3, T=0 → o_dat converts to 3 after one reduce pass; o_iter_cnt=0.
- x=N−1, T=1 → result 1; x=0, T=5 → result 0.
- x=5, T=2, i_rdy held 0 for 20 cycles after o_val → o_val/o_dat stable for all 20 cycles, o_rdy=0 throughout. Result 625 transfers on i_rdy=1; o_rdy=1 the next cycle.
- Reset asserted mid-WAIT of a T=100 job, released 3 cycles later → o_val, o_busy, o_iter_cnt=0. No o_val for 2×pass-latency cycles. A new job x=2, T=1 then returns 4.
- With POLY_MOD_SQ_ITER_CKPT_EN, CKPT_LOG2=1, x=2, T=4 → o_ckpt_val pulses at iter 2 (value 16) and iter 4 (value 65536, unreduced form allowed); final o_dat 65536.
